// File: rtl/cascade_stage_controller_pkg.sv
// Shared definitions for the Haar cascade controller: FSM states, classifier ROM
// layout and the signed saturating adder also used by the window scanner.
package cascade_stage_controller_pkg;

   // Fractional bits of every ROM value, feature value and sum; compares stay raw signed.
   localparam int FIXED_POINT_FRAC = 16;

   // Classifier ROM layout: one cascade header word, then per stage a header and per node a record.
   localparam int STAGE_HDR_WORDS = 2;
   localparam int NODE_WORDS      = 4;
   localparam int HDR_OFS_NNODES  = 0;
   localparam int HDR_OFS_THR     = 1;
   localparam int NODE_OFS_FEAT   = 0;
   localparam int NODE_OFS_THR    = 1;
   localparam int NODE_OFS_LEFT   = 2;
   localparam int NODE_OFS_RIGHT  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_NSTG,
      ST_RD_SHDR,
      ST_RD_NODE,
      ST_LAUNCH,
      ST_WAIT_FC,
      ST_EVAL,
      ST_STG_CHK,
      ST_FINISH
   } state_e;

   // Sign-extended operands are added at 64 bits, then clamped to a signed 'width'-bit range.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        width);
      logic signed [63:0] sum;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      sum   = a + b;
      if (sum > max_v) return max_v;
      if (sum < min_v) return min_v;
      return sum;
   endfunction

endpackage

// File: rtl/cascade_stage_controller_if.sv
// Controller-side bus: classifier ROM read port plus the feature_calculator handshake.
interface cascade_stage_controller_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int CLS_ADDR_WIDTH = 16
);
   logic [CLS_ADDR_WIDTH-1:0]   cls_addr;
   logic [DATA_WIDTH-1:0]       cls_data;
   logic                        fc_start;
   logic [11:0]                 fc_feature_index;
   logic [7:0]                  fc_window_x;
   logic [7:0]                  fc_window_y;
   logic [7:0]                  fc_window_scale;
   logic signed [DATA_WIDTH-1:0] fc_feature_value;
   logic                        fc_done;

   modport master (
      output cls_addr, fc_start, fc_feature_index, fc_window_x, fc_window_y, fc_window_scale,
      input  cls_data, fc_feature_value, fc_done
   );

   modport slave (
      input  cls_addr, fc_start, fc_feature_index, fc_window_x, fc_window_y, fc_window_scale,
      output cls_data, fc_feature_value, fc_done
   );
endinterface

// File: rtl/cascade_stage_controller_fc_watchdog.sv
// Counts WAIT_FC cycles since the last feature launch; flags expiry once past TIMEOUT.
module fc_watchdog #(
   parameter int TIMEOUT = 4095
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 2);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_expired = (r_count > CW'(TIMEOUT));
endmodule

// File: rtl/cascade_stage_controller.sv
// Walks the Haar cascade tables for one window, launches a feature calculation per node,
// accumulates stage votes with saturation and rejects on the first failing stage.
module cascade_stage_controller
   import cascade_stage_controller_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int CLS_ADDR_WIDTH   = 16,
   parameter int CLS_BASE_ADDR    = 0,
   parameter int FC_TIMEOUT       = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] window_x,
   input  logic [7:0] window_y,
   input  logic [7:0] window_scale,
   output logic       busy,
   output logic       done,
   output logic       detected,
   output logic [7:0] stages_passed,
   output logic       timeout_err,
   cascade_stage_controller_if.master bus
);
   localparam logic [CLS_ADDR_WIDTH-1:0] ADDR_BASE = CLS_ADDR_WIDTH'(CLS_BASE_ADDR);
   localparam logic [CLS_ADDR_WIDTH-1:0] ADDR_ONE  = CLS_ADDR_WIDTH'(1);

   state_e                        r_state;
   logic [CLS_ADDR_WIDTH-1:0]     r_cls_addr;
   logic [1:0]                    r_word;
   logic [7:0]                    r_num_stages;
   logic [7:0]                    r_num_nodes;
   logic [7:0]                    r_node_idx;
   logic [7:0]                    r_stages_passed;
   logic [11:0]                   r_feat_idx;
   logic signed [DATA_WIDTH-1:0]  r_stage_thr;
   logic signed [DATA_WIDTH-1:0]  r_node_thr;
   logic signed [DATA_WIDTH-1:0]  r_left_val;
   logic signed [DATA_WIDTH-1:0]  r_right_val;
   logic signed [DATA_WIDTH-1:0]  r_addend;
   logic signed [DATA_WIDTH-1:0]  r_stage_sum;
   logic [7:0]                    r_win_x;
   logic [7:0]                    r_win_y;
   logic [7:0]                    r_win_scale;
   logic                          r_busy;
   logic                          r_done;
   logic                          r_detected;
   logic                          r_timeout_err;
   logic                          r_fc_start;
   logic                          w_wd_expired;

   fc_watchdog #(.TIMEOUT(FC_TIMEOUT)) u_fc_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (r_state == ST_LAUNCH),
      .i_enable  (r_state == ST_WAIT_FC),
      .o_expired (w_wd_expired)
   );

   // ROM data lags the address by one cycle, so the pointer is bumped on every transition
   // into a read cycle and is therefore always one word ahead of the word being consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_cls_addr      <= ADDR_BASE;
         r_word          <= '0;
         r_num_stages    <= '0;
         r_num_nodes     <= '0;
         r_node_idx      <= '0;
         r_stages_passed <= '0;
         r_feat_idx      <= '0;
         r_stage_thr     <= '0;
         r_node_thr      <= '0;
         r_left_val      <= '0;
         r_right_val     <= '0;
         r_addend        <= '0;
         r_stage_sum     <= '0;
         r_win_x         <= '0;
         r_win_y         <= '0;
         r_win_scale     <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_detected      <= 1'b0;
         r_timeout_err   <= 1'b0;
         r_fc_start      <= 1'b0;
      end else begin
         // NOTE: single-cycle pulses default low here; a later non-blocking write in the case wins.
         r_done     <= 1'b0;
         r_fc_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_win_x         <= window_x;
                  r_win_y         <= window_y;
                  r_win_scale     <= window_scale;
                  r_detected      <= 1'b0;
                  r_timeout_err   <= 1'b0;
                  r_stages_passed <= '0;
                  r_busy          <= 1'b1;
                  r_cls_addr      <= r_cls_addr + ADDR_ONE;
                  r_state         <= ST_RD_NSTG;
               end
            end
            ST_RD_NSTG: begin
               r_num_stages <= bus.cls_data[7:0];
               if (bus.cls_data[7:0] == 8'd0) begin
                  r_detected <= 1'b1;
                  r_done     <= 1'b1;
                  r_state    <= ST_FINISH;
               end else begin
                  r_word     <= '0;
                  r_cls_addr <= r_cls_addr + ADDR_ONE;
                  r_state    <= ST_RD_SHDR;
               end
            end
            ST_RD_SHDR: begin
               if (r_word == 2'(HDR_OFS_NNODES)) begin
                  r_num_nodes <= bus.cls_data[7:0];
                  r_word      <= r_word + 2'd1;
                  r_cls_addr  <= r_cls_addr + ADDR_ONE;
               end else begin
                  r_stage_thr <= bus.cls_data;
                  r_stage_sum <= '0;
                  r_node_idx  <= '0;
                  r_word      <= '0;
                  if (r_num_nodes == 8'd0) begin
                     r_state <= ST_STG_CHK;
                  end else begin
                     r_cls_addr <= r_cls_addr + ADDR_ONE;
                     r_state    <= ST_RD_NODE;
                  end
               end
            end
            ST_RD_NODE: begin
               case (r_word)
                  2'(NODE_OFS_FEAT):  r_feat_idx  <= bus.cls_data[11:0];
                  2'(NODE_OFS_THR):   r_node_thr  <= bus.cls_data;
                  2'(NODE_OFS_LEFT):  r_left_val  <= bus.cls_data;
                  default:            r_right_val <= bus.cls_data;
               endcase
               if (r_word == 2'(NODE_WORDS - 1)) begin
                  r_word     <= '0;
                  r_fc_start <= 1'b1;
                  r_state    <= ST_LAUNCH;
               end else begin
                  r_word     <= r_word + 2'd1;
                  r_cls_addr <= r_cls_addr + ADDR_ONE;
               end
            end
            ST_LAUNCH: begin
               r_state <= ST_WAIT_FC;
            end
            ST_WAIT_FC: begin
               // A result arriving on the expiry cycle still counts as a result.
               if (bus.fc_done) begin
                  r_addend <= (bus.fc_feature_value < r_node_thr) ? r_left_val : r_right_val;
                  r_state  <= ST_EVAL;
               end else if (w_wd_expired) begin
                  r_timeout_err <= 1'b1;
                  r_detected    <= 1'b0;
                  r_done        <= 1'b1;
                  r_state       <= ST_FINISH;
               end
            end
            ST_EVAL: begin
               r_stage_sum <= DATA_WIDTH'(sat_add(64'(r_stage_sum), 64'(r_addend), DATA_WIDTH));
               if (r_node_idx == r_num_nodes - 8'd1) begin
                  r_state <= ST_STG_CHK;
               end else begin
                  r_node_idx <= r_node_idx + 8'd1;
                  r_word     <= '0;
                  r_cls_addr <= r_cls_addr + ADDR_ONE;
                  r_state    <= ST_RD_NODE;
               end
            end
            ST_STG_CHK: begin
               if (r_stage_sum < r_stage_thr) begin
                  r_detected <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= ST_FINISH;
               end else begin
                  r_stages_passed <= r_stages_passed + 8'd1;
                  if (r_stages_passed + 8'd1 == r_num_stages) begin
                     r_detected <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= ST_FINISH;
                  end else begin
                     r_word     <= '0;
                     r_cls_addr <= r_cls_addr + ADDR_ONE;
                     r_state    <= ST_RD_SHDR;
                  end
               end
            end
            ST_FINISH: begin
               r_busy     <= 1'b0;
               r_cls_addr <= ADDR_BASE;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy                 = r_busy;
   assign done                 = r_done;
   assign detected             = r_detected;
   assign stages_passed        = r_stages_passed;
   assign timeout_err          = r_timeout_err;
   assign bus.cls_addr         = r_cls_addr;
   assign bus.fc_start         = r_fc_start;
   assign bus.fc_feature_index = r_feat_idx;
   assign bus.fc_window_x      = r_win_x;
   assign bus.fc_window_y      = r_win_y;
   assign bus.fc_window_scale  = r_win_scale;
endmodule

// File: tb/tb_cascade_stage_controller.sv
// Scoreboard bench: each window's expected outcome is queued at start and compared at done,
// against a registered ROM model and a fixed-latency feature calculator model.
module tb_cascade_stage_controller;
   localparam int DW      = 32;
   localparam int AW      = 16;
   localparam int BASE    = 8;
   localparam int TIMEOUT = 40;
   localparam int FC_LAT  = 3;
   localparam int LIMIT   = 2000;

   typedef struct {
      logic       det;
      logic [7:0] sp;
      logic       to;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] window_x, window_y, window_scale;
   logic       busy, done, detected, timeout_err;
   logic [7:0] stages_passed;

   cascade_stage_controller_if #(.DATA_WIDTH(DW), .CLS_ADDR_WIDTH(AW)) bus_if ();

   cascade_stage_controller #(
      .DATA_WIDTH(DW), .CLS_ADDR_WIDTH(AW), .CLS_BASE_ADDR(BASE), .FC_TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .window_x(window_x), .window_y(window_y), .window_scale(window_scale),
      .busy(busy), .done(done), .detected(detected),
      .stages_passed(stages_passed), .timeout_err(timeout_err),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Registered classifier ROM.
   logic [DW-1:0] rom [0:255];
   int wp;
   always @(posedge clk) bus_if.cls_data <= rom[bus_if.cls_addr[7:0]];

   task automatic rom_clear();
      for (int i = 0; i < 256; i++) rom[i] = '0;
      wp = BASE;
   endtask

   task automatic put(input logic [DW-1:0] w);
      rom[wp] = w;
      wp++;
   endtask

   task automatic node(input logic [11:0] fi, input logic [DW-1:0] thr,
                       input logic [DW-1:0] lv, input logic [DW-1:0] rv);
      put({20'd0, fi}); put(thr); put(lv); put(rv);
   endtask

   // Stimulus owned by the main process, consumed by the feature calculator model.
   logic signed [DW-1:0] fv_arr [0:255];
   int          n_fv = 0;
   logic [11:0] exp_fi[$];
   exp_t        sb_q[$];
   bit          fc_withhold = 1'b0;
   int          stray_req = 0;

   // Observations owned by the feature calculator model.
   logic [11:0] obs_fi [0:255];
   int          n_launch = 0;
   int          rd_launch = 0;

   task automatic expect_node(input logic [11:0] fi, input logic signed [DW-1:0] fv);
      exp_fi.push_back(fi);
      fv_arr[n_fv] = fv;
      n_fv++;
   endtask

   initial begin
      int fv_rd = 0;
      int stray_served = 0;
      bus_if.fc_done          = 1'b0;
      bus_if.fc_feature_value = '0;
      forever begin
         @(negedge clk);
         if (bus_if.fc_start) begin
            obs_fi[n_launch[7:0]] = bus_if.fc_feature_index;
            n_launch++;
            if (!fc_withhold) begin
               @(posedge clk);
               repeat (FC_LAT - 1) @(posedge clk);
               #1;
               bus_if.fc_done          = 1'b1;
               bus_if.fc_feature_value = fv_arr[fv_rd[7:0]];
               fv_rd++;
               @(posedge clk);
               #1 bus_if.fc_done = 1'b0;
            end
         end else if (stray_req > stray_served) begin
            @(posedge clk);
            #1;
            bus_if.fc_done          = 1'b1;
            bus_if.fc_feature_value = 32'sh0000_7fff;
            @(posedge clk);
            #1 bus_if.fc_done = 1'b0;
            stray_served++;
         end
      end
   end

   function automatic exp_t mk_exp(input logic det, input logic [7:0] sp, input logic to,
                                   input int lat);
      exp_t e;
      e.det = det; e.sp = sp; e.to = to; e.lat = lat;
      return e;
   endfunction

   task automatic run_window(input string name, input logic [7:0] wx, input logic [7:0] wy,
                             input logic [7:0] ws, input exp_t e);
      exp_t p;
      int   cyc;
      sb_q.push_back(e);
      @(posedge clk);
      #1; start = 1'b1; window_x = wx; window_y = wy; window_scale = ws;
      @(posedge clk);
      #1; start = 1'b0; window_x = ~wx; window_y = ~wy; window_scale = ~ws;
      @(negedge clk);
      check({name, "_busy_after_start"}, busy, 1'b1);
      cyc = 1;
      while (!done && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
      p = sb_q.pop_front();
      check({name, "_done_seen"}, done, 1'b1);
      if (done) begin
         check({name, "_detected"}, detected, p.det);
         check({name, "_stages_passed"}, stages_passed, p.sp);
         check({name, "_timeout_err"}, timeout_err, p.to);
         check({name, "_latency"}, cyc, p.lat);
         check({name, "_busy_with_done"}, busy, 1'b1);
         check({name, "_win_x"}, bus_if.fc_window_x, wx);
         check({name, "_win_y"}, bus_if.fc_window_y, wy);
         check({name, "_win_scale"}, bus_if.fc_window_scale, ws);
         check({name, "_launch_count"}, n_launch - rd_launch, exp_fi.size());
         while (rd_launch < n_launch && exp_fi.size() > 0) begin
            check({name, "_feature_index"}, obs_fi[rd_launch[7:0]], exp_fi.pop_front());
            rd_launch++;
         end
      end
      rd_launch = n_launch;
      exp_fi.delete();
      @(negedge clk);
      check({name, "_done_one_cycle"}, done, 1'b0);
      check({name, "_busy_after_done"}, busy, 1'b0);
      check({name, "_detected_held"}, detected, p.det);
   endtask

   task automatic load_single_node();
      rom_clear();
      put(1);
      put(1); put(32'h0001_0000);
      node(12'h005, 32'h0, 32'h0002_0000, 32'hFFFF_0000);
   endtask

   initial begin
      int w;
      int spurious;
      rst = 1'b1; start = 1'b0;
      window_x = '0; window_y = '0; window_scale = '0;
      rom_clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_detected", detected, 1'b0);
      check("reset_stages_passed", stages_passed, 8'd0);
      check("reset_timeout_err", timeout_err, 1'b0);
      check("reset_cls_addr", bus_if.cls_addr, 16'(BASE));
      check("reset_fc_start", bus_if.fc_start, 1'b0);

      // A stray fc_done while idle must not start or finish anything.
      stray_req++;
      repeat (4) @(negedge clk);
      check("stray_busy", busy, 1'b0);
      check("stray_done", done, 1'b0);

      // Empty cascade: immediate detection.
      rom_clear();
      put(0);
      run_window("zero_stages", 8'h11, 8'h22, 8'h80, mk_exp(1'b1, 8'd0, 1'b0, 2));

      // One stage with no nodes: sum 0 equals threshold 0, stage passes.
      rom_clear();
      put(1);
      put(0); put(0);
      run_window("zero_nodes", 8'h12, 8'h23, 8'h40, mk_exp(1'b1, 8'd1, 1'b0, 5));

      // Basic detection: fv=-5 < 0 selects left=+2.0, which clears 1.0.
      load_single_node();
      expect_node(12'h005, -32'sd5);
      run_window("single_node", 8'h05, 8'h06, 8'hC0,
                 mk_exp(1'b1, 8'd1, 1'b0, 1 + 2 + (6 + FC_LAT) + 1 + 1));

      // Early reject: stage0 sums to 0.5 < 1.0, stage1 never launched.
      rom_clear();
      put(2);
      put(2); put(32'h0001_0000);
      node(12'h011, 32'h0, 32'hFFFF_0000, 32'h0000_4000);
      node(12'h012, 32'h0, 32'h0000_4000, 32'hFFFF_0000);
      put(1); put(32'h0);
      node(12'h777, 32'h0, 32'h1, 32'h1);
      expect_node(12'h011, 32'sd10);
      expect_node(12'h012, -32'sd1);
      run_window("early_reject", 8'h30, 8'h31, 8'h20,
                 mk_exp(1'b0, 8'd0, 1'b0, 1 + 2 + 2 * (6 + FC_LAT) + 1 + 1));

      // Equality: fv == node_thr takes right_val; stage_sum == stage_thr passes.
      rom_clear();
      put(2);
      put(1); put(32'h0000_8000);
      node(12'h031, 32'h0003_0000, 32'hFFFE_0000, 32'h0000_8000);
      put(1); put(32'h0001_0000);
      node(12'h032, 32'hFFFF_0000, 32'h0, 32'h0001_0000);
      expect_node(12'h031, 32'sh0003_0000);
      expect_node(12'h032, 32'shFFFF_0000);
      run_window("equality", 8'h40, 8'h41, 8'h10,
                 mk_exp(1'b1, 8'd2, 1'b0, 1 + 2 * (2 + (6 + FC_LAT) + 1) + 1));

      // Saturation: positive clamp meets 0x7FFF_FFFF exactly; negative clamp stays below
      // 0x8000_0001 where a wrapped sum would read as zero and pass.
      rom_clear();
      put(2);
      put(3); put(32'h7FFF_FFFF);
      node(12'h101, 32'h0, 32'h7FFF_0000, 32'h0);
      node(12'h102, 32'h0, 32'h7FFF_0000, 32'h0);
      node(12'h103, 32'h0, 32'h7FFF_0000, 32'h0);
      put(2); put(32'h8000_0001);
      node(12'h201, 32'h0, 32'h0, 32'h8000_0000);
      node(12'h202, 32'h0, 32'h0, 32'h8000_0000);
      expect_node(12'h101, -32'sd1);
      expect_node(12'h102, -32'sd1);
      expect_node(12'h103, -32'sd1);
      expect_node(12'h201, 32'sd5);
      expect_node(12'h202, 32'sd5);
      run_window("saturation", 8'h50, 8'h51, 8'hFF,
                 mk_exp(1'b0, 8'd1, 1'b0,
                        1 + (2 + 3 * (6 + FC_LAT) + 1) + (2 + 2 * (6 + FC_LAT) + 1) + 1));

      // Watchdog: no fc_done at all; expiry after TIMEOUT+2 waiting cycles.
      load_single_node();
      fc_withhold = 1'b1;
      exp_fi.push_back(12'h005);
      run_window("timeout", 8'h60, 8'h61, 8'h08, mk_exp(1'b0, 8'd0, 1'b1, TIMEOUT + 11));
      fc_withhold = 1'b0;

      // Reset while waiting on the feature calculator: back to idle, no done pulse.
      load_single_node();
      fc_withhold = 1'b1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      w = 0;
      while (!bus_if.fc_start && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("rst_mid_launch_seen", bus_if.fc_start, 1'b1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      fc_withhold = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_cls_addr", bus_if.cls_addr, 16'(BASE));
      spurious = 0;
      repeat (10) begin
         if (done) spurious++;
         @(negedge clk);
      end
      check("rst_mid_no_done", spurious, 0);
      rd_launch = n_launch;

      // Clean rerun after the aborted window.
      expect_node(12'h005, -32'sd5);
      run_window("after_reset", 8'h70, 8'h71, 8'h99,
                 mk_exp(1'b1, 8'd1, 1'b0, 1 + 2 + (6 + FC_LAT) + 1 + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
